// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and helpers for the 7-segment scan controller.
// Segment patterns are active-high {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [7:0] SEG_OFF = 8'h00;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: frame update valid/ready bundle.
// master = frame source, slave = scan controller.
interface seg_scan_ctrl_if #(
  parameter int N_DIGITS = 4
) ();

  logic                  valid;
  logic                  ready;
  logic [4*N_DIGITS-1:0] data;
  logic [N_DIGITS-1:0]   dp;
  logic                  blank_lz;

  modport master (
    output valid, data, dp, blank_lz,
    input  ready
  );

  modport slave (
    input  valid, data, dp, blank_lz,
    output ready
  );

endinterface

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: nibble + dp + blank -> 8-bit {dp,g..a} pattern.
// blank clears the seven segments only; dp passes through.
module seg_hex_decode
  import seg_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nib,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] pat
);

  logic [7:0] raw;

  always_comb begin
    raw = {dp, blank ? 7'h00 : HEX_SEG[nib]};
    pat = ACTIVE_LOW ? ~raw : raw;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: double-buffered multiplexed 7-segment scan controller.
// Define SEG_BLINK_EN to add blink_mask and BLINK_FRAMES.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int N_DIGITS   = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 500,
  parameter bit ACTIVE_LOW = 1'b1
`ifdef SEG_BLINK_EN
  , parameter int BLINK_FRAMES = 250
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  seg_scan_ctrl_if.slave      upd,
`ifdef SEG_BLINK_EN
  input  logic [N_DIGITS-1:0] blink_mask,
`endif
  output logic [7:0]          seg_out,
  output logic [N_DIGITS-1:0] sel,
  output logic                frame_tick
);

  localparam int IW = idx_w(N_DIGITS);
  localparam int CW = idx_w(SCAN_DIV);
  localparam int DW = 4 * N_DIGITS;
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [7:0] OFF_PAT = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic [N_DIGITS-1:0] SEL_RST =
    ACTIVE_LOW ? ~N_DIGITS'(1) : N_DIGITS'(1);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                pend_q, pend_d;
  logic [DW-1:0]       sh_data_q, sh_data_d;
  logic [N_DIGITS-1:0] sh_dp_q, sh_dp_d;
  logic                sh_lz_q, sh_lz_d;
  logic [DW-1:0]       ac_data_q, ac_data_d;
  logic [N_DIGITS-1:0] ac_dp_q, ac_dp_d;
  logic                ac_lz_q, ac_lz_d;
  logic [7:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] sel_q, sel_d;

  logic                slot_end;
  logic                nz;
  logic                lz_blank;
  logic                off;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic [7:0]          dec_pat;
  logic [N_DIGITS-1:0] onehot;

`ifdef SEG_BLINK_EN
  localparam int BW = idx_w(BLINK_FRAMES);
  localparam logic [BW-1:0] BLAST = BW'(BLINK_FRAMES - 1);
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
`endif

  assign upd.ready = ~pend_q;
  assign seg_out   = seg_q;
  assign sel       = sel_q;

  seg_hex_decode #(
    .ACTIVE_LOW(ACTIVE_LOW)
  ) u_dec (
    .nib  (cur_nib),
    .dp   (cur_dp),
    .blank(lz_blank),
    .pat  (dec_pat)
  );

  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    pend_d    = pend_q;
    sh_data_d = sh_data_q;
    sh_dp_d   = sh_dp_q;
    sh_lz_d   = sh_lz_q;
    ac_data_d = ac_data_q;
    ac_dp_d   = ac_dp_q;
    ac_lz_d   = ac_lz_q;

    slot_end   = (cnt_q == CNT_LAST);
    frame_tick = slot_end && (idx_q == IDX_LAST);

    if (slot_end) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // commit needs pend_q, capture needs !pend_q: never both
    if (frame_tick && pend_q) begin
      ac_data_d = sh_data_q;
      ac_dp_d   = sh_dp_q;
      ac_lz_d   = sh_lz_q;
      pend_d    = 1'b0;
    end
    if (upd.valid && !pend_q) begin
      sh_data_d = upd.data;
      sh_dp_d   = upd.dp;
      sh_lz_d   = upd.blank_lz;
      pend_d    = 1'b1;
    end

    cur_nib = ac_data_q[idx_q*4 +: 4];
    cur_dp  = ac_dp_q[idx_q];

    nz = 1'b0;
    for (int j = 0; j < N_DIGITS; j++) begin
      if (j >= int'(idx_q) && ac_data_q[j*4 +: 4] != 4'h0)
        nz = 1'b1;
    end
    lz_blank = ac_lz_q && !nz && (idx_q != '0);

    off = int'(cnt_q) < BLANK_CYC;
`ifdef SEG_BLINK_EN
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (frame_tick) begin
      bcnt_d = (bcnt_q == BLAST) ? '0 : bcnt_q + 1'b1;
      if (bcnt_q == BLAST)
        phase_d = ~phase_q;
    end
    off = off | (phase_q & blink_mask[idx_q]);
`endif

    seg_d = off ? OFF_PAT : dec_pat;

    onehot        = '0;
    onehot[idx_q] = 1'b1;
    sel_d = ACTIVE_LOW ? ~onehot : onehot;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      pend_q    <= 1'b0;
      sh_data_q <= '0;
      sh_dp_q   <= '0;
      sh_lz_q   <= 1'b0;
      ac_data_q <= '0;
      ac_dp_q   <= '0;
      ac_lz_q   <= 1'b0;
      seg_q     <= OFF_PAT;
      sel_q     <= SEL_RST;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      sh_data_q <= sh_data_d;
      sh_dp_q   <= sh_dp_d;
      sh_lz_q   <= sh_lz_d;
      ac_data_q <= ac_data_d;
      ac_dp_q   <= ac_dp_d;
      ac_lz_q   <= ac_lz_d;
      seg_q     <= seg_d;
      sel_q     <= sel_d;
    end
  end

`ifdef SEG_BLINK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end
`endif

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized self-checking bench with a frame-level model.
// Define SEG_BLINK_EN to also exercise blinking.
module tb_seg_scan_ctrl;

  localparam int N   = 4;
  localparam int DIV = 8;
  localparam int BLK = 2;
  localparam int FR  = N * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] seg_out;
  logic [3:0] sel;
  logic       frame_tick;

  seg_scan_ctrl_if #(.N_DIGITS(N)) upd ();

`ifdef SEG_BLINK_EN
  logic [3:0] blink_mask = 4'b0000;
`endif

  seg_scan_ctrl #(
    .N_DIGITS  (N),
    .SCAN_DIV  (DIV),
    .BLANK_CYC (BLK),
    .ACTIVE_LOW(1'b1)
`ifdef SEG_BLINK_EN
    , .BLINK_FRAMES(2)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .upd       (upd),
`ifdef SEG_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .seg_out   (seg_out),
    .sel       (sel),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // active-low glyphs for 0..F, dp off
  logic [7:0] tbl [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
  logic [7:0] k1234 [4] = '{8'h99, 8'hB0, 8'h24, 8'hF9};
  logic [7:0] k0050 [4] = '{8'hC0, 8'h92, 8'hFF, 8'hFF};
  logic [7:0] k0000 [4] = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};

  int          pos = 0;
  int          out_pos = -1;
  int          ticks = 0;
  logic [15:0] a_data = '0, s_data = '0, o_data = '0;
  logic [3:0]  a_dp = '0, s_dp = '0;
  logic        a_lz = 1'b0, s_lz = 1'b0, o_lz = 1'b0;
  logic        pend = 1'b0;
  logic        acc = 1'b0;
  logic [7:0]  e_seg = 8'hFF;
  logic [3:0]  e_sel = 4'b1110;
  logic        e_tick = 1'b0;
  logic        e_rdy = 1'b1;

  function automatic logic [7:0] exp_pat(input int p);
    int         c;
    int         i;
    logic [3:0] nb;
    logic [7:0] v;
    c = p % DIV;
    i = p / DIV;
    if (c < BLK) return 8'hFF;
`ifdef SEG_BLINK_EN
    if (((ticks / 2) % 2) == 1 && blink_mask[i]) return 8'hFF;
`endif
    nb = 4'((a_data >> (4 * i)) & 16'hF);
    if (a_lz && i > 0 && (a_data >> (4 * i)) == 16'h0) v = 8'hFF;
    else v = tbl[nb];
    if (a_dp[i]) v[7] = 1'b0;
    return v;
  endfunction

  // advance one clock and move the frame-level model with it
  task automatic step();
    logic [7:0]  ns;
    logic [3:0]  nl;
    logic        cm, ac, lz;
    logic [15:0] d;
    logic [3:0]  dp;
    ns = exp_pat(pos);
    nl = ~(4'b0001 << (pos / DIV));
    cm = (pos == FR - 1) && pend;
    ac = upd.valid && !pend;
    d  = upd.data;
    dp = upd.dp;
    lz = upd.blank_lz;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      pos = 0; ticks = 0; out_pos = -1;
      a_data = '0; a_dp = '0; a_lz = 1'b0;
      o_data = '0; o_lz = 1'b0;
      pend = 1'b0; acc = 1'b0;
      e_seg = 8'hFF; e_sel = 4'b1110;
    end else begin
      e_seg = ns; e_sel = nl; out_pos = pos; acc = ac;
      o_data = a_data; o_lz = a_lz;
      if (pos == FR - 1) ticks++;
      if (cm) begin
        a_data = s_data; a_dp = s_dp; a_lz = s_lz; pend = 1'b0;
      end
      if (ac) begin
        s_data = d; s_dp = dp; s_lz = lz; pend = 1'b1;
      end
      pos = (pos + 1) % FR;
    end
    e_tick = (pos == FR - 1) && rst_n;
    e_rdy  = !pend;
  endtask

  task automatic test_reset();
    int nt;
    rst_n = 1'b0;
    upd.valid = 1'b0; upd.data = '0; upd.dp = '0; upd.blank_lz = 1'b0;
    repeat (3) step();
    total++;
    if ({seg_out, sel, upd.ready, frame_tick} !== {8'hFF, 4'b1110, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset got seg=%h sel=%b rdy=%b tick=%b want seg=ff sel=1110 rdy=1 tick=0",
               seg_out, sel, upd.ready, frame_tick);
    end
    rst_n = 1'b1;
    nt = 0;
    for (int k = 0; k < 2 * FR; k++) begin
      step();
      if (frame_tick === 1'b1) nt++;
      total++;
      if ({seg_out, sel, frame_tick, upd.ready} !== {e_seg, e_sel, e_tick, e_rdy}) begin
        bad++;
        $display("FAIL scan t=%0t got %h %b %b %b want %h %b %b %b", $time,
                 seg_out, sel, frame_tick, upd.ready, e_seg, e_sel, e_tick, e_rdy);
      end
    end
    total++;
    if (nt !== 2) begin
      bad++;
      $display("FAIL tick_count got %0d want 2", nt);
    end
  endtask

  task automatic test_frame();
    while (pos != 13) step();
    upd.valid = 1'b1; upd.data = 16'h1234; upd.dp = 4'b0100; upd.blank_lz = 1'b0;
    step();
    upd.valid = 1'b0;
    for (int k = 0; k < 3 * FR; k++) begin
      step();
      total++;
      if ({seg_out, sel, frame_tick, upd.ready} !== {e_seg, e_sel, e_tick, e_rdy}) begin
        bad++;
        $display("FAIL frame t=%0t got %h %b %b %b want %h %b %b %b", $time,
                 seg_out, sel, frame_tick, upd.ready, e_seg, e_sel, e_tick, e_rdy);
      end
      if (o_data == 16'h1234 && out_pos >= 0 && out_pos % DIV >= BLK) begin
        total++;
        if (seg_out !== k1234[out_pos / DIV]) begin
          bad++;
          $display("FAIL digit1234 got %h want %h", seg_out, k1234[out_pos / DIV]);
        end
      end
    end
  endtask

  task automatic test_busy();
    int guard;
    upd.valid = 1'b1; upd.data = 16'hABCD; upd.dp = 4'b0000; upd.blank_lz = 1'b0;
    step();
    upd.data = 16'h0F0F; upd.dp = 4'b1001;
    guard = 0;
    while (!acc && guard < 3 * FR) begin
      step();
      guard++;
      total++;
      if ({seg_out, sel, frame_tick, upd.ready} !== {e_seg, e_sel, e_tick, e_rdy}) begin
        bad++;
        $display("FAIL busy t=%0t got %h %b %b %b want %h %b %b %b", $time,
                 seg_out, sel, frame_tick, upd.ready, e_seg, e_sel, e_tick, e_rdy);
      end
    end
    upd.valid = 1'b0;
    for (int k = 0; k < 2 * FR; k++) begin
      step();
      total++;
      if ({seg_out, sel, frame_tick, upd.ready} !== {e_seg, e_sel, e_tick, e_rdy}) begin
        bad++;
        $display("FAIL busy_drain t=%0t got %h %b %b %b want %h %b %b %b", $time,
                 seg_out, sel, frame_tick, upd.ready, e_seg, e_sel, e_tick, e_rdy);
      end
    end
  endtask

  task automatic test_tick_capture();
    int guard;
    guard = 0;
    while ((pend || pos != FR - 1) && guard < 4 * FR) begin
      step();
      guard++;
    end
    upd.valid = 1'b1; upd.data = 16'h5A5A; upd.dp = 4'b0011; upd.blank_lz = 1'b0;
    step();
    upd.valid = 1'b0;
    for (int k = 0; k < 3 * FR; k++) begin
      step();
      total++;
      if ({seg_out, sel, frame_tick, upd.ready} !== {e_seg, e_sel, e_tick, e_rdy}) begin
        bad++;
        $display("FAIL tick_cap t=%0t got %h %b %b %b want %h %b %b %b", $time,
                 seg_out, sel, frame_tick, upd.ready, e_seg, e_sel, e_tick, e_rdy);
      end
    end
  endtask

  task automatic test_lz();
    for (int f = 0; f < 2; f++) begin
      upd.valid = 1'b1; upd.dp = 4'b0000; upd.blank_lz = 1'b1;
      upd.data = (f == 0) ? 16'h0050 : 16'h0000;
      step();
      upd.valid = 1'b0;
      for (int k = 0; k < 3 * FR; k++) begin
        step();
        total++;
        if ({seg_out, sel, frame_tick, upd.ready} !== {e_seg, e_sel, e_tick, e_rdy}) begin
          bad++;
          $display("FAIL lz t=%0t got %h %b %b %b want %h %b %b %b", $time,
                   seg_out, sel, frame_tick, upd.ready, e_seg, e_sel, e_tick, e_rdy);
        end
        if (o_lz && out_pos >= 0 && out_pos % DIV >= BLK) begin
          total++;
          if (o_data == 16'h0050 && seg_out !== k0050[out_pos / DIV]) begin
            bad++;
            $display("FAIL lz0050 got %h want %h", seg_out, k0050[out_pos / DIV]);
          end
          if (o_data == 16'h0000 && seg_out !== k0000[out_pos / DIV]) begin
            bad++;
            $display("FAIL lz0000 got %h want %h", seg_out, k0000[out_pos / DIV]);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      if (!upd.valid || acc) begin
        upd.valid    = ($urandom_range(0, 3) == 0);
        upd.data     = 16'($urandom);
        upd.dp       = 4'($urandom);
        upd.blank_lz = 1'($urandom);
        if ($urandom_range(0, 2) == 0) upd.data = upd.data & 16'h00FF;
      end
      rst_n = !(k >= 300 && k < 302);
      step();
      total++;
      if ({seg_out, sel, frame_tick, upd.ready} !== {e_seg, e_sel, e_tick, e_rdy}) begin
        bad++;
        $display("FAIL random t=%0t got %h %b %b %b want %h %b %b %b", $time,
                 seg_out, sel, frame_tick, upd.ready, e_seg, e_sel, e_tick, e_rdy);
      end
    end
    rst_n = 1'b1;
    upd.valid = 1'b0;
  endtask

`ifdef SEG_BLINK_EN
  task automatic test_blink();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    blink_mask = 4'b0001;
    upd.valid = 1'b1; upd.data = 16'h8888; upd.dp = 4'b1111; upd.blank_lz = 1'b0;
    step();
    upd.valid = 1'b0;
    for (int k = 0; k < 6 * FR; k++) begin
      step();
      total++;
      if ({seg_out, sel, frame_tick, upd.ready} !== {e_seg, e_sel, e_tick, e_rdy}) begin
        bad++;
        $display("FAIL blink t=%0t got %h %b %b %b want %h %b %b %b", $time,
                 seg_out, sel, frame_tick, upd.ready, e_seg, e_sel, e_tick, e_rdy);
      end
    end
    blink_mask = 4'b0000;
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_busy();
    test_tick_capture();
    test_lz();
    test_random();
`ifdef SEG_BLINK_EN
    test_blink();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
